// File: rtl/vram_pkg.sv
// Shared framebuffer geometry, grant-state encoding and write-queue entry type
// for the VRAM port arbiter and its write FIFO.
package vram_pkg;

    localparam int H_PIXELS    = 160;
    localparam int V_PIXELS    = 144;
    localparam int FB_SIZE     = H_PIXELS * V_PIXELS;
    localparam int VRAM_ADDR_W = 15;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_entry_t;

    // True when the pixel address lies inside the visible framebuffer.
    function automatic logic fb_in_range(input logic [VRAM_ADDR_W-1:0] addr);
        return (32'(addr) < 32'(FB_SIZE));
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// In-order write queue with full/empty flags; the head entry is shown ahead
// so the arbiter can drive the RAM port in the cycle after a pop is granted.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  wr_entry_t i_data,
    input  logic      i_pop,
    output wr_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wr_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_count == (PTR_W+1)'(0));
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_head   = r_mem[r_rdPtr];

    // Entry storage, written at the tail.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= PTR_W'(0);
            r_rdPtr <= PTR_W'(0);
            r_count <= (PTR_W+1)'(0);
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single-port VRAM between queued capture writes and VGA scan-out
// reads: reads win by default, writes are forced through when the queue fills or starves.
module vram_port_arbiter
    import vram_pkg::*;
#(
    parameter int WFIFO_DEPTH    = 4,
    parameter int MAX_WRITE_WAIT = 8,
    parameter int ADDR_W         = VRAM_ADDR_W,
    parameter int DATA_W         = VRAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wrValid,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    output logic              o_wrReady,
    input  logic              i_rdReq,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic              o_rdReady,
    output logic [DATA_W-1:0] o_rdData,
    output logic              o_rdDataValid,
    output logic              o_ramEn,
    output logic              o_ramWe,
    output logic [ADDR_W-1:0] o_ramAddr,
    output logic [DATA_W-1:0] o_ramWData,
    input  logic [DATA_W-1:0] i_ramRData,
    output logic [7:0]        o_dropCount,
    output logic              o_errSticky
);

    localparam int WAIT_W = $clog2(MAX_WRITE_WAIT + 1);

    wr_entry_t         w_pushEntry;
    wr_entry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_wrAccept;
    logic              w_wrInRange;
    logic              w_rdInRange;
    logic              w_push;
    logic              w_pop;
    logic              w_waitSat;
    gnt_e              w_gntNext;
    gnt_e              r_gnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_rdOor0;
    logic              r_rdVld1;
    logic              r_rdOor1;

    assign w_wrInRange      = fb_in_range(VRAM_ADDR_W'(i_wrAddr));
    assign w_rdInRange      = fb_in_range(VRAM_ADDR_W'(i_rdAddr));
    assign o_wrReady        = !w_full;
    assign w_wrAccept       = i_wrValid && !w_full;
    assign w_push           = w_wrAccept && w_wrInRange;
    assign w_pushEntry.addr = VRAM_ADDR_W'(i_wrAddr);
    assign w_pushEntry.data = VRAM_DATA_W'(i_wrData);
    assign w_waitSat        = (r_waitCnt >= WAIT_W'(MAX_WRITE_WAIT));

    vram_wr_fifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_pushEntry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Grant decision: a waiting write preempts a read only when the queue is full or starved.
    always_comb begin
        w_gntNext = GNT_NONE;
        if (i_rst) begin
            w_gntNext = GNT_NONE;
        end else if (!w_empty && (!i_rdReq || w_full || w_waitSat)) begin
            w_gntNext = GNT_WR;
        end else if (i_rdReq) begin
            w_gntNext = GNT_RD;
        end else begin
            w_gntNext = GNT_NONE;
        end
    end

    assign w_pop     = (w_gntNext == GNT_WR);
    assign o_rdReady = (w_gntNext == GNT_RD);

    // Starvation counter for the queue head.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_waitCnt <= WAIT_W'(0);
        end else if (w_empty || w_pop) begin
            r_waitCnt <= WAIT_W'(0);
        end else if (!w_waitSat) begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
        end
    end

    // Grant state and RAM port; address/data hold when the port is idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gnt      <= GNT_NONE;
            r_rdOor0   <= 1'b0;
            o_ramEn    <= 1'b0;
            o_ramWe    <= 1'b0;
            o_ramAddr  <= ADDR_W'(0);
            o_ramWData <= DATA_W'(0);
        end else begin
            r_gnt    <= w_gntNext;
            r_rdOor0 <= (w_gntNext == GNT_RD) && !w_rdInRange;
            case (w_gntNext)
                GNT_WR: begin
                    o_ramEn    <= 1'b1;
                    o_ramWe    <= 1'b1;
                    o_ramAddr  <= ADDR_W'(w_head.addr);
                    o_ramWData <= DATA_W'(w_head.data);
                end
                GNT_RD: begin
                    // Out-of-range reads still occupy the slot but never touch the RAM.
                    o_ramEn   <= w_rdInRange;
                    o_ramWe   <= 1'b0;
                    o_ramAddr <= i_rdAddr;
                end
                default: begin
                    o_ramEn <= 1'b0;
                    o_ramWe <= 1'b0;
                end
            endcase
        end
    end

    // Read return pipeline: RAM data arrives one cycle after the address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdVld1      <= 1'b0;
            r_rdOor1      <= 1'b0;
            o_rdDataValid <= 1'b0;
            o_rdData      <= DATA_W'(0);
        end else begin
            r_rdVld1      <= (r_gnt == GNT_RD);
            r_rdOor1      <= r_rdOor0;
            o_rdDataValid <= r_rdVld1;
            if (r_rdVld1) begin
                o_rdData <= r_rdOor1 ? DATA_W'(0) : i_ramRData;
            end
        end
    end

    // Error bookkeeping for filtered addresses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dropCount <= 8'd0;
            o_errSticky <= 1'b0;
        end else begin
            if (w_wrAccept && !w_wrInRange && (o_dropCount != 8'hFF)) begin
                o_dropCount <= o_dropCount + 8'd1;
            end
            if ((w_wrAccept && !w_wrInRange) || ((w_gntNext == GNT_RD) && !w_rdInRange)) begin
                o_errSticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed scenarios then random traffic, every
// cycle compared with a transaction-level model of the arbitration rules.
module tb_vram_port_arbiter;
    import vram_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXW  = 8;

    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } went_t;

    typedef struct {
        int         due;
        logic [7:0] d;
    } rexp_t;

    logic        clk = 1'b0;
    logic        i_rst, i_wrValid, i_rdReq;
    logic [14:0] i_wrAddr, i_rdAddr;
    logic [7:0]  i_wrData, i_ramRData;
    logic        o_wrReady, o_rdReady, o_rdDataValid, o_ramEn, o_ramWe, o_errSticky;
    logic [7:0]  o_rdData, o_ramWData, o_dropCount;
    logic [14:0] o_ramAddr;

    always #5 clk = ~clk;

    vram_port_arbiter #(
        .WFIFO_DEPTH(DEPTH), .MAX_WRITE_WAIT(MAXW), .ADDR_W(15), .DATA_W(8)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_wrValid(i_wrValid), .i_wrAddr(i_wrAddr), .i_wrData(i_wrData), .o_wrReady(o_wrReady),
        .i_rdReq(i_rdReq), .i_rdAddr(i_rdAddr), .o_rdReady(o_rdReady),
        .o_rdData(o_rdData), .o_rdDataValid(o_rdDataValid),
        .o_ramEn(o_ramEn), .o_ramWe(o_ramWe), .o_ramAddr(o_ramAddr), .o_ramWData(o_ramWData),
        .i_ramRData(i_ramRData), .o_dropCount(o_dropCount), .o_errSticky(o_errSticky)
    );

    // Unwritten locations return a fixed address-derived pattern.
    function automatic logic [7:0] fill(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    // Behavioural single-port RAM attached to the DUT.
    logic [7:0] dev_mem [0:32767];
    bit         dev_wr  [0:32767];
    always @(posedge clk) begin
        if (o_ramEn) begin
            if (o_ramWe) begin
                dev_mem[o_ramAddr] <= o_ramWData;
                dev_wr[o_ramAddr]  <= 1'b1;
            end else begin
                i_ramRData <= dev_wr[o_ramAddr] ? dev_mem[o_ramAddr] : fill(o_ramAddr);
            end
        end
    end

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    went_t       wq[$];
    rexp_t       rq[$];
    logic [7:0]  ref_mem [0:32767];
    bit          ref_wr  [0:32767];
    int          wait_m;
    logic        e_en, e_we, e_err;
    logic [14:0] e_addr;
    logic [7:0]  e_data;
    int          e_drop;

    // Stimulus state
    logic        s_rst, wr_pend, rd_pend, rd_stream, chk_en;
    logic [14:0] wr_addr, rd_addr;
    logic [7:0]  wr_data;

    function automatic logic [7:0] ref_read(input logic [14:0] a);
        return ref_wr[a] ? ref_mem[a] : fill(a);
    endfunction

    task automatic step();
        int    n;
        bit    full, gwr, grd, exp_v;
        went_t h;
        @(posedge clk);
        #1;
        i_rst     = s_rst;
        i_wrValid = wr_pend;
        i_wrAddr  = wr_addr;
        i_wrData  = wr_data;
        i_rdReq   = rd_pend;
        i_rdAddr  = rd_addr;
        #1;
        n     = wq.size();
        full  = (n >= DEPTH);
        gwr   = !s_rst && (n > 0) && (!rd_pend || full || wait_m >= MAXW);
        grd   = !s_rst && rd_pend && !gwr;
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        if (chk_en) begin
            check_val("wrReady",   32'(o_wrReady),     32'(!full));
            check_val("rdReady",   32'(o_rdReady),     32'(grd));
            check_val("ramEn",     32'(o_ramEn),       32'(e_en));
            check_val("ramWe",     32'(o_ramWe),       32'(e_we));
            check_val("ramAddr",   32'(o_ramAddr),     32'(e_addr));
            check_val("ramWData",  32'(o_ramWData),    32'(e_data));
            check_val("rdValid",   32'(o_rdDataValid), 32'(exp_v));
            if (exp_v) check_val("rdData", 32'(o_rdData), 32'(rq[0].d));
            check_val("dropCount", 32'(o_dropCount),   32'(e_drop));
            check_val("errSticky", 32'(o_errSticky),   32'(e_err));
        end
        if (exp_v) void'(rq.pop_front());
        if (s_rst) begin
            wq.delete();
            rq.delete();
            wait_m = 0;
            e_en = 1'b0; e_we = 1'b0; e_addr = 15'd0; e_data = 8'd0;
            e_drop = 0; e_err = 1'b0;
        end else begin
            if (gwr) begin
                h = wq.pop_front();
                e_en = 1'b1; e_we = 1'b1; e_addr = h.a; e_data = h.d;
                ref_mem[h.a] = h.d;
                ref_wr[h.a]  = 1'b1;
            end else if (grd) begin
                e_en   = (int'(rd_addr) < FB_SIZE);
                e_we   = 1'b0;
                e_addr = rd_addr;
                rq.push_back('{cyc + 3, (int'(rd_addr) < FB_SIZE) ? ref_read(rd_addr) : 8'h00});
                if (int'(rd_addr) >= FB_SIZE) e_err = 1'b1;
            end else begin
                e_en = 1'b0; e_we = 1'b0;
            end
            wait_m = (n == 0 || gwr) ? 0 : ((wait_m < MAXW) ? wait_m + 1 : MAXW);
            if (wr_pend && !full) begin
                if (int'(wr_addr) < FB_SIZE) wq.push_back('{wr_addr, wr_data});
                else begin
                    if (e_drop < 255) e_drop++;
                    e_err = 1'b1;
                end
                wr_pend = 1'b0;
            end
            if (grd) begin
                rd_pend = rd_stream;
                if (rd_stream) rd_addr = 15'($urandom_range(0, FB_SIZE - 1));
            end
        end
        cyc++;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic do_wr(input logic [14:0] a, input logic [7:0] d);
        wr_pend = 1'b1; wr_addr = a; wr_data = d;
        for (int k = 0; k < 32 && wr_pend; k++) step();
        check_val("wr_accept_bound", 32'(wr_pend), 32'd0);
    endtask

    task automatic do_rd(input logic [14:0] a);
        rd_pend = 1'b1; rd_addr = a;
        for (int k = 0; k < 32 && rd_pend; k++) step();
        check_val("rd_accept_bound", 32'(rd_pend), 32'd0);
    endtask

    function automatic logic [14:0] gen_addr();
        int r = $urandom_range(0, 15);
        if (r == 0) return 15'(FB_SIZE + $urandom_range(0, 32767 - FB_SIZE));
        else if (r < 8) return 15'($urandom_range(0, 31));
        else return 15'($urandom_range(0, FB_SIZE - 1));
    endfunction

    initial begin
        wait_m = 0; e_en = 1'b0; e_we = 1'b0; e_addr = 15'd0; e_data = 8'd0;
        e_drop = 0; e_err = 1'b0;
        wr_pend = 1'b0; rd_pend = 1'b0; rd_stream = 1'b0;
        wr_addr = 15'd0; rd_addr = 15'd0; wr_data = 8'd0;
        chk_en = 1'b0; s_rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check_val("rst_rdData", 32'(o_rdData), 32'd0);
        s_rst = 1'b0;

        // Lone write, then seed 0x5A at 159 and read it back alone.
        do_wr(15'h0000, 8'hE3); run(4);
        do_wr(15'd159, 8'h5A);  run(4);
        do_rd(15'd159);         run(6);

        // Starvation under a continuous read stream.
        rd_stream = 1'b1; rd_pend = 1'b1; rd_addr = 15'd300;
        run(2);
        do_wr(15'd100, 8'h77);
        run(14);
        rd_stream = 1'b0; run(6);

        // Fill the queue while reads hog the port.
        rd_stream = 1'b1; rd_pend = 1'b1; rd_addr = 15'd400;
        run(1);
        for (int i = 0; i < 4; i++) do_wr(15'(10 + i), 8'(8'hA0 + i));
        do_wr(15'd14, 8'hB4);
        run(12);
        rd_stream = 1'b0; run(6);

        // Out-of-range write and read.
        do_wr(15'd23040, 8'h11); run(3);
        do_rd(15'd30000);        run(6);

        // Reset with writes queued and reads in flight.
        rd_stream = 1'b1; rd_pend = 1'b1; rd_addr = 15'd500;
        run(1);
        for (int i = 0; i < 3; i++) do_wr(15'(600 + i), 8'(8'h30 + i));
        rd_stream = 1'b0; rd_pend = 1'b0; wr_pend = 1'b0;
        s_rst = 1'b1; step(); s_rst = 1'b0;
        run(6);

        // Random traffic with occasional resets.
        for (int t = 0; t < 3000; t++) begin
            if (!wr_pend && $urandom_range(0, 99) < 40) begin
                wr_pend = 1'b1; wr_addr = gen_addr(); wr_data = 8'($urandom);
            end
            if (!rd_pend && $urandom_range(0, 99) < 50) begin
                rd_pend = 1'b1; rd_addr = gen_addr();
            end
            s_rst = ($urandom_range(0, 599) == 0);
            step();
            s_rst = 1'b0;
        end
        wr_pend = 1'b0; rd_pend = 1'b0;
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
